// File: rtl/multicycle_mips_core_pkg.sv
// Shared definitions for the multicycle MIPS-subset core.
// Holds opcode/funct encodings, the FSM state enum, the ALU operation enum
// and the HALT encoding. Imported by every other core file.
package core_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;  // BLTZ (rt=0) / BGEZ (rt=1)
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_t;

endpackage

// File: rtl/multicycle_mips_core_if.sv
// Data-memory bus between the core (master) and a memory/bench (slave).
// req/we/addr/wdata are held by the master until a cycle with ack=1;
// rdata is valid in the ack cycle.
interface multicycle_mips_core_if #(
    parameter int DATA_W  = 32,
    parameter int DMEM_AW = 10
);
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/multicycle_mips_core_alu.sv
// core_alu: combinational ALU shared for arithmetic, address generation
// and set-less-than. Shifts operate on b by shamt.
// Ports: a, b (DATA_W operands), shamt (5-bit shift), alu_op, result.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  alu_op_t           alu_op,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = DATA_W'($signed(a) < $signed(b));
            ALU_SLTU:  result = DATA_W'(a < b);
            ALU_SLL:   result = b << shamt;
            ALU_SRL:   result = b >> shamt;
            ALU_SRA:   result = DATA_W'($signed(b) >>> shamt);
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core: one-instruction-at-a-time MIPS-subset core.
// FSM FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH; HALT is absorbing.
// Ports: clk, rst_n (async active-low); imem_addr/imem_rdata (combinational
// instruction memory); dmem (req/ack data bus, master side); dbg_raddr/
// dbg_rdata (combinational GPR peek); halted; instr_retired (1-cycle pulse);
// cycle_count/retire_count (perf counters).
// Optional feature macro: CORE_PERF_CNT_EN enables the two 32-bit counters;
// without it both ports read 0.
module multicycle_mips_core
    import core_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 8,
    parameter int              DMEM_AW  = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    multicycle_mips_core_if.master dmem,
    input  logic [4:0]             dbg_raddr,
    output logic [DATA_W-1:0]      dbg_rdata,
    output logic                   halted,
    output logic                   instr_retired,
    output logic [31:0]            cycle_count,
    output logic [31:0]            retire_count
);
    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [31:0]         ir_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, imm_reg, aluout_reg, mdr_reg;
    logic                req_reg, we_reg, retired_reg, retire_next;
    logic [DMEM_AW-1:0]  addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   gpr [32];

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign shamt  = ir_reg[10:6];
    assign funct  = ir_reg[5:0];
    assign imm16  = ir_reg[15:0];

    // Immediate formation (used in DECODE)
    logic signed [15:0] imm_s;
    logic signed [31:0] lui_s;
    logic [DATA_W-1:0]  imm_ext;
    assign imm_s = imm16;
    assign lui_s = {imm16, 16'h0000};
    always_comb begin
        imm_ext = DATA_W'(imm_s);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = DATA_W'(imm16);
            OP_LUI:                   imm_ext = DATA_W'(lui_s);
            default:                  imm_ext = DATA_W'(imm_s);
        endcase
    end

    logic [PC_W-1:0] pc_plus1, br_target;
    logic            a_zero, a_neg;
    assign pc_plus1  = pc_reg + PC_W'(1);
    assign br_target = pc_plus1 + imm_reg[PC_W-1:0];
    assign a_zero    = (a_reg == '0);
    assign a_neg     = a_reg[DATA_W-1];

    // Instruction decode, evaluated from IR; meaningful in EXEC/MEM/WB.
    logic            is_alu, is_mem, is_halt, use_imm, redirect, link;
    alu_op_t         alu_op;
    logic [4:0]      dest, link_dest;
    logic [PC_W-1:0] jump_pc;
    always_comb begin
        is_alu = 1'b0; is_mem = 1'b0; is_halt = 1'b0; use_imm = 1'b0;
        redirect = 1'b0; link = 1'b0; alu_op = ALU_ADD;
        dest = rt; link_dest = 5'd31; jump_pc = br_target;
        case (opcode)
            OP_RTYPE: begin
                is_alu = 1'b1;
                dest   = rd;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_JR: begin
                        is_alu = 1'b0; redirect = 1'b1; jump_pc = a_reg[PC_W-1:0];
                    end
                    F_JALR: begin
                        is_alu = 1'b0; redirect = 1'b1; jump_pc = a_reg[PC_W-1:0];
                        link = 1'b1; link_dest = rd;
                    end
                    default: is_alu = 1'b0;  // unknown funct retires as NOP
                endcase
            end
            OP_REGIMM: redirect = (rt == 5'd0) ? a_neg : ((rt == 5'd1) ? !a_neg : 1'b0);
            OP_J:      begin redirect = 1'b1; jump_pc = ir_reg[PC_W-1:0]; end
            OP_JAL:    begin redirect = 1'b1; jump_pc = ir_reg[PC_W-1:0]; link = 1'b1; end
            OP_BEQ:    redirect = (a_reg == b_reg);
            OP_BNE:    redirect = (a_reg != b_reg);
            OP_BLEZ:   redirect = a_neg || a_zero;
            OP_BGTZ:   redirect = !a_neg && !a_zero;
            OP_ADDI, OP_ADDIU: begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_ADD;   end
            OP_SLTI:           begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT;   end
            OP_SLTIU:          begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_SLTU;  end
            OP_ANDI:           begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_AND;   end
            OP_ORI:            begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_OR;    end
            OP_XORI:           begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_XOR;   end
            OP_LUI:            begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_PASSB; end
            OP_LW, OP_SW:      begin is_mem = 1'b1; use_imm = 1'b1; end
            OP_HALT:           is_halt = 1'b1;
            default: ;
        endcase
    end

    logic [DATA_W-1:0] alu_result;
    core_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (use_imm ? imm_reg : b_reg),
        .shamt  (shamt),
        .alu_op (alu_op),
        .result (alu_result)
    );

    logic mem_done;
    assign mem_done = req_reg && dmem.ack;  // ack only counts while a request is out

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= FETCH;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: state_next = EXEC;
            EXEC: begin
                if (is_halt)     state_next = HALT;
                else if (is_mem) state_next = MEM;
                else if (is_alu) state_next = WB;
                else             state_next = FETCH;
            end
            MEM:     if (mem_done) state_next = we_reg ? FETCH : WB;
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // FSM: outputs (retire, PC update, GPR write port)
    logic              gpr_we;
    logic [4:0]        gpr_waddr;
    logic [DATA_W-1:0] gpr_wdata;
    always_comb begin
        retire_next = 1'b0;
        pc_next     = pc_reg;
        gpr_we      = 1'b0;
        gpr_waddr   = dest;
        gpr_wdata   = aluout_reg;
        case (state_reg)
            EXEC: if (!is_halt && !is_mem && !is_alu) begin
                // branches, jumps and NOPs finish here; links write now
                retire_next = 1'b1;
                pc_next     = redirect ? jump_pc : pc_plus1;
                gpr_we      = link;
                gpr_waddr   = link_dest;
                gpr_wdata   = DATA_W'(pc_plus1);
            end
            MEM: if (mem_done && we_reg) begin
                retire_next = 1'b1;
                pc_next     = pc_plus1;
            end
            WB: begin
                retire_next = 1'b1;
                pc_next     = pc_plus1;
                gpr_we      = 1'b1;
                gpr_wdata   = is_mem ? mdr_reg : aluout_reg;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            imm_reg     <= '0;
            aluout_reg  <= '0;
            mdr_reg     <= '0;
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            retired_reg <= 1'b0;
        end else begin
            retired_reg <= retire_next;
            pc_reg      <= pc_next;
            case (state_reg)
                FETCH:  ir_reg <= imem_rdata;
                DECODE: begin
                    a_reg   <= gpr[rs];
                    b_reg   <= gpr[rt];
                    imm_reg <= imm_ext;
                end
                EXEC: begin
                    aluout_reg <= alu_result;
                    if (is_mem) begin
                        req_reg   <= 1'b1;
                        we_reg    <= (opcode == OP_SW);
                        addr_reg  <= alu_result[DMEM_AW-1:0];
                        wdata_reg <= b_reg;
                    end
                end
                MEM: if (mem_done) begin
                    req_reg <= 1'b0;
                    mdr_reg <= dmem.rdata;
                end
                default: ;
            endcase
        end
    end

    // Register file; entry 0 is never written so it reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (gpr_we && gpr_waddr != 5'd0) begin
            gpr[gpr_waddr] <= gpr_wdata;
        end
    end

    assign imem_addr     = pc_reg;
    assign dbg_rdata     = gpr[dbg_raddr];
    assign halted        = (state_reg == HALT);
    assign instr_retired = retired_reg;
    assign dmem.req      = req_reg;
    assign dmem.we       = we_reg;
    assign dmem.addr     = addr_reg;
    assign dmem.wdata    = wdata_reg;

`ifdef CORE_PERF_CNT_EN
    logic [31:0] cycle_cnt_reg, retire_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            // counted alongside the pulse so the count matches it cycle for cycle
            if (retire_next) retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end
    assign cycle_count  = cycle_cnt_reg;
    assign retire_count = retire_cnt_reg;
`else
    assign cycle_count  = '0;
    assign retire_count = '0;
`endif

endmodule
